dec_8b10b_sync_ctrl: RTL

//  Receive-side controller for the combinational decoder_8b10b. Feeds aligned 10-bit

---
 rtl/dec_8b10b_sync_ctrl_if.sv | 31 +++
 rtl/dec_8b10b_sync_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dec_8b10b_sync_ctrl_if.sv
// Signal bundle between the 8b/10b receive controller, its decoder and the downstream byte sink.
// Handshake: a symbol moves when in_valid=1 and a byte moves when out_valid=1; there is no ready.
interface dec_8b10b_sync_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [9:0]       in_data;
  logic             dec_df;
  logic [9:0]       dec_di;
  logic             dec_de;
  logic [7:0]       dec_do;
  logic             dec_k;
  logic             dec_viol;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_k;
  logic             out_err;
  logic             sync;
  logic [CNT_W-1:0] err_total;
  logic [1:0]       state;

  modport slave (
    input  in_valid, in_data, dec_de, dec_do, dec_k, dec_viol,
    output dec_df, dec_di, out_valid, out_data, out_k, out_err, sync, err_total, state
  );

  modport master (
    output in_valid, in_data, dec_de, dec_do, dec_k, dec_viol,
    input  dec_df, dec_di, out_valid, out_data, out_k, out_err, sync, err_total, state
  );
endinterface

// File: rtl/dec_8b10b_sync_ctrl.sv
// Receive-side controller for a combinational 8b/10b decoder: running disparity,
// comma-based sync acquire/loss with error hysteresis, registered in-sync byte output.
module dec_8b10b_sync_ctrl #(
  parameter int COMMA_CNT = 3,
  parameter int ERR_MAX   = 4,
  parameter int GOOD_RUN  = 4,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  dec_8b10b_sync_ctrl_if.slave bus
);

  localparam int C_W = $clog2(COMMA_CNT + 1);
  localparam int B_W = $clog2(ERR_MAX + 1);
  localparam int G_W = $clog2(GOOD_RUN + 1);

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } state_t;

  state_t           state;
  logic             rd;
  logic [C_W-1:0]   ccnt;
  logic [B_W-1:0]   bcnt;
  logic [G_W-1:0]   gcnt;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_k;
  logic             out_err;
  logic [CNT_W-1:0] err_total;

  logic good;
  logic comma;

  assign good  = bus.in_valid && !bus.dec_viol;
  assign comma = good && bus.dec_k &&
                 ((bus.dec_do == 8'h3C) || (bus.dec_do == 8'hBC) || (bus.dec_do == 8'hFC));

  assign bus.dec_df    = rd;
  assign bus.dec_di    = bus.in_data;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_k     = out_k;
  assign bus.out_err   = out_err;
  assign bus.sync      = (state == SYNC);
  assign bus.err_total = err_total;
  assign bus.state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOS;
      rd        <= 1'b0;
      ccnt      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k     <= 1'b0;
      out_err   <= 1'b0;
      err_total <= '0;
    end else begin
      // Output decisions use the state as it was before this symbol.
      out_valid <= bus.in_valid && (state == SYNC);
      if (bus.in_valid) begin
        if (state == SYNC) begin
          out_data <= bus.dec_do;
          out_k    <= bus.dec_k;
          out_err  <= bus.dec_viol;
          if (bus.dec_viol && (err_total != '1)) begin
            err_total <= err_total + 1'b1;
          end
        end

        // While hunting, a violation may just mean we guessed the wrong disparity.
        if (good) begin
          rd <= bus.dec_de;
        end else if (state == LOS) begin
          rd <= ~rd;
        end

        case (state)
          LOS: begin
            if (comma) begin
              if (COMMA_CNT == 1) begin
                state <= SYNC;
                ccnt  <= '0;
                bcnt  <= '0;
                gcnt  <= '0;
              end else begin
                state <= ACQ;
                ccnt  <= C_W'(1);
              end
            end
          end
          ACQ: begin
            if (bus.dec_viol) begin
              state <= LOS;
              ccnt  <= '0;
            end else if (comma) begin
              if (ccnt == C_W'(COMMA_CNT - 1)) begin
                state <= SYNC;
                ccnt  <= '0;
                bcnt  <= '0;
                gcnt  <= '0;
              end else begin
                ccnt <= ccnt + 1'b1;
              end
            end
          end
          SYNC: begin
            if (bus.dec_viol) begin
              gcnt <= '0;
              if (bcnt == B_W'(ERR_MAX - 1)) begin
                state <= LOS;
                ccnt  <= '0;
                bcnt  <= '0;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else if (gcnt == G_W'(GOOD_RUN - 1)) begin
              // A clean run retires one bad credit; gcnt keeps cycling at zero credit.
              gcnt <= '0;
              if (bcnt != '0) begin
                bcnt <= bcnt - 1'b1;
              end
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          default: begin
            state <= LOS;
          end
        endcase
      end
    end
  end

endmodule
